regfile_sweep_bank: RTL and testbench
=====================================

Name: regfile_sweep_bank

Overview:
- Parametrised register bank, successor to the fixed 8 x 32-bit enable-per-register bank.
- Addressed write port plus two registered read ports, with write-to-read bypass.
- Built-in clear engine: zeroes every entry, one per cycle, on request.
- Sits between datapath writeback and operand fetch in the matrix datapath.

Parameters:
- WIDTH, 32, data bits per entry; multiple of 8.
- DEPTH, 8, number of entries; >= 2, need not be a power of two.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- wr_addr  in  AW  write index.
- wr_data  in  WIDTH  write data.
- wr_ack  out  1  write committed this cycle; combinational.
- rd0_addr  in  AW  read port 0 index.
- rd0_data  out  WIDTH  read port 0 data; registered.
- rd1_addr  in  AW  read port 1 index.
- rd1_data  out  WIDTH  read port 1 data; registered.
- clr_req  in  1  start clear sweep; level-sampled.
- busy  out  1  sweep in progress.
- clr_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (reset_n=0, async): all entries 0; rd0_data, rd1_data = 0; busy = 0; clr_done = 0; sweep index = 0; state IDLE.
- FSM states:
  - IDLE: if clr_req, go to SWEEP next cycle.
  - SWEEP: entry[idx] <= 0 each cycle, idx increments; at idx = DEPTH-1 go to DONE and idx returns to 0.
  - DONE: clr_done = 1 for one cycle; go to IDLE.
- busy = 1 in SWEEP and DONE. A sweep takes DEPTH+1 cycles from the clr_req cycle to the clr_done cycle.
- Writes:
  - wr_ack = wr_en & ~busy & (wr_addr < DEPTH).
  - On wr_ack, entry[wr_addr] <= wr_data at the clock edge.
  - While busy, writes are dropped (wr_ack=0), with no queuing.
  - Out-of-range wr_addr is ignored.
- Reads:
  - 1-cycle latency: rdN_data <= value of entry[rdN_addr] as of this cycle.
  - Bypass: if a write to the same address is acked this cycle, rdN_data takes wr_data.
  - If the sweep zeroes rdN_addr this cycle, rdN_data takes 0.
  - Out-of-range rdN_addr returns 0.
  - Both ports may read the same address.
- Simultaneous events:
  - wr_en and clr_req in IDLE in the same cycle: the write commits, the sweep starts next cycle and later zeroes that entry.
  - clr_req while busy is ignored; it does not re-arm.
  - clr_req held high through DONE restarts a sweep from IDLE on the following cycle.
- reset_n asserted mid-sweep: immediate return to IDLE, all entries 0, no clr_done pulse.

Optional Feature:
- Macro: REGFILE_BYTE_STROBE_EN.
- Defined:
  - Adds input port wr_be, WIDTH/8 bits.
  - On wr_ack, only bytes with wr_be[i]=1 are updated; other bytes hold.
  - Bypass data is the merge of the old entry and the strobed bytes.
  - wr_be = 0 still acks but changes nothing.
- Undefined: no wr_be port; every acked write updates the full word.

Test Plan:
- Reset, then read addr 0..7 on both ports -> every rd data = 0x00000000, busy = 0.
- Write 0xDEADBEEF to addr 3, read addr 3 on rd0 next cycle -> rd0_data = 0xDEADBEEF one cycle after the read address is applied.
- Write 0x12345678 to addr 5 while rd1_addr = 5 in the same cycle -> rd1_data = 0x12345678 next cycle (bypass).
- Fill all 8 entries, pulse clr_req -> busy high for 9 cycles, clr_done pulses on cycle 9; wr_en to addr 2 during the sweep gives wr_ack = 0; afterwards all reads = 0.
- Start a sweep, assert reset_n=0 at sweep cycle 4 -> all outputs 0 at once, no clr_done, next write/read behaves normally.
- With REGFILE_BYTE_STROBE_EN: entry 1 = 0xAABBCCDD, write 0x11223344 with wr_be = 4'b0101 -> entry 1 reads 0xAA22CC44.

Source files
------------

// File: rtl/regfile_sweep_bank.sv
// ============================================================================
// Module   : regfile_sweep_bank
// Function : parametrised register bank with one write port, two registered
//            read ports with write bypass, and a one-entry-per-cycle clear
//            sweep. Optional byte strobes: REGFILE_BYTE_STROBE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sweep_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
`ifdef REGFILE_BYTE_STROBE_EN
  input  logic [WIDTH/8-1:0] wr_be,
`endif
  output logic             wr_ack,
  input  logic [AW-1:0]    rd0_addr,
  output logic [WIDTH-1:0] rd0_data,
  input  logic [AW-1:0]    rd1_addr,
  output logic [WIDTH-1:0] rd1_data,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd0_q, rd0_d;
  logic [WIDTH-1:0] rd1_q, rd1_d;
  logic [WIDTH-1:0] wr_word;
  logic             sweep_clr;
  logic             wr_in_range, rd0_in_range, rd1_in_range;

  // DEPTH need not be a power of two, so addresses are range-checked.
  assign wr_in_range  = 32'(wr_addr)  < 32'(DEPTH);
  assign rd0_in_range = 32'(rd0_addr) < 32'(DEPTH);
  assign rd1_in_range = 32'(rd1_addr) < 32'(DEPTH);

  assign busy      = (state_q != S_IDLE);
  assign clr_done  = (state_q == S_DONE);
  assign sweep_clr = (state_q == S_SWEEP);
  assign wr_ack    = wr_en & ~busy & wr_in_range;

`ifdef REGFILE_BYTE_STROBE_EN
  // Merged word is both the stored value and the bypass value.
  always_comb begin
    wr_word = wr_in_range ? mem_q[wr_addr] : '0;
    for (int b = 0; b < WIDTH/8; b++) begin
      if (wr_be[b]) wr_word[8*b +: 8] = wr_data[8*b +: 8];
    end
  end
`else
  assign wr_word = wr_data;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE:  if (clr_req) state_d = S_SWEEP;
      S_SWEEP: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A write and a sweep clear never coincide: writes are refused while busy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (wr_ack)    mem_d[wr_addr] = wr_word;
    if (sweep_clr) mem_d[idx_q]   = '0;
  end

  always_comb begin
    rd0_d = rd0_in_range ? mem_q[rd0_addr] : '0;
    if (!rd0_in_range)                         rd0_d = '0;
    else if (sweep_clr && (idx_q == rd0_addr)) rd0_d = '0;
    else if (wr_ack && (wr_addr == rd0_addr))  rd0_d = wr_word;

    rd1_d = rd1_in_range ? mem_q[rd1_addr] : '0;
    if (!rd1_in_range)                         rd1_d = '0;
    else if (sweep_clr && (idx_q == rd1_addr)) rd1_d = '0;
    else if (wr_ack && (wr_addr == rd1_addr))  rd1_d = wr_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd0_data = rd0_q;
  assign rd1_data = rd1_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sweep_bank.sv
// ============================================================================
// Module   : tb_regfile_sweep_bank
// Function : directed self-checking bench for regfile_sweep_bank (8 entries)
//            plus a 5-entry instance for out-of-range addressing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sweep_bank;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en, clr_req, wr_ack, busy, clr_done;
  logic [2:0]  wr_addr, rd0_addr, rd1_addr;
  logic [31:0] wr_data, rd0_data, rd1_data;

  logic        s_wr_en, s_wr_ack, s_busy, s_clr_done;
  logic [2:0]  s_wr_addr, s_rd0_addr, s_rd1_addr;
  logic [31:0] s_wr_data, s_rd0_data, s_rd1_data;

`ifdef REGFILE_BYTE_STROBE_EN
  logic [3:0]  wr_be, s_wr_be;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_sweep_bank #(.WIDTH(32), .DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef REGFILE_BYTE_STROBE_EN
    .wr_be(wr_be),
`endif
    .wr_ack(wr_ack),
    .rd0_addr(rd0_addr), .rd0_data(rd0_data),
    .rd1_addr(rd1_addr), .rd1_data(rd1_data),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  regfile_sweep_bank #(.WIDTH(32), .DEPTH(5)) dut5 (
    .clk(clk), .reset_n(reset_n),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
`ifdef REGFILE_BYTE_STROBE_EN
    .wr_be(s_wr_be),
`endif
    .wr_ack(s_wr_ack),
    .rd0_addr(s_rd0_addr), .rd0_data(s_rd0_data),
    .rd1_addr(s_rd1_addr), .rd1_data(s_rd1_data),
    .clr_req(1'b0), .busy(s_busy), .clr_done(s_clr_done)
  );

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick; tick;
    n_cmp++;
    if (busy !== 1'b0 || clr_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_status busy=%b clr_done=%b expected 0/0", busy, clr_done);
    end
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd0_addr = 3'(a);
      rd1_addr = 3'(7 - a);
      tick;
      n_cmp++;
      if (rd0_data !== 32'h0 || rd1_data !== 32'h0) begin
        n_err++;
        $display("FAIL reset_read a=%0d rd0=%h rd1=%h expected 0", a, rd0_data, rd1_data);
      end
    end
  endtask

  task automatic test_write_read;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (wr_ack !== 1'b1) begin
      n_err++;
      $display("FAIL wr_ack_idle got=%b expected 1", wr_ack);
    end
    tick;
    wr_en = 1'b0; rd0_addr = 3'd3;
    tick;
    n_cmp++;
    if (rd0_data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL write_read rd0=%h expected deadbeef", rd0_data);
    end
  endtask

  task automatic test_bypass;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h12345678;
    rd1_addr = 3'd5; rd0_addr = 3'd3;
    tick;
    wr_en = 1'b0;
    n_cmp++;
    if (rd1_data !== 32'h12345678 || rd0_data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL bypass rd1=%h expected 12345678 rd0=%h expected deadbeef", rd1_data, rd0_data);
    end
  endtask

  task automatic test_sweep;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 32'h100 + i;
      tick;
    end
    wr_en = 1'b0;
    clr_req = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL sweep_pre_busy got=%b expected 0", busy);
    end
    tick;
    clr_req = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      wr_en = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || clr_done !== (k == 9)) begin
        n_err++;
        $display("FAIL sweep_cycle k=%0d busy=%b clr_done=%b expected 1/%b", k, busy, clr_done, k == 9);
      end
      if (k == 2) begin
        rd0_addr = 3'd5;
        rd1_addr = 3'd1;
      end
      if (k == 3) begin
        n_cmp++;
        if (rd0_data !== 32'h105 || rd1_data !== 32'h0) begin
          n_err++;
          $display("FAIL sweep_read rd0=%h expected 105 rd1=%h expected 0", rd0_data, rd1_data);
        end
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'hFFFFFFFF;
        #1;
        n_cmp++;
        if (wr_ack !== 1'b0) begin
          n_err++;
          $display("FAIL sweep_wr_ack got=%b expected 0", wr_ack);
        end
      end
      tick;
    end
    wr_en = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || clr_done !== 1'b0) begin
      n_err++;
      $display("FAIL sweep_end busy=%b clr_done=%b expected 0/0", busy, clr_done);
    end
    for (int a = 0; a < 8; a++) begin
      rd0_addr = 3'(a);
      rd1_addr = 3'(a);
      tick;
      n_cmp++;
      if (rd0_data !== 32'h0 || rd1_data !== 32'h0) begin
        n_err++;
        $display("FAIL sweep_cleared a=%0d rd0=%h rd1=%h expected 0", a, rd0_data, rd1_data);
      end
    end
  endtask

  task automatic test_wr_with_clr;
    bit seen;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'h00000044; clr_req = 1'b1;
    #1;
    n_cmp++;
    if (wr_ack !== 1'b1) begin
      n_err++;
      $display("FAIL wr_with_clr_ack got=%b expected 1", wr_ack);
    end
    tick;
    wr_en = 1'b0; clr_req = 1'b0; rd0_addr = 3'd4;
    tick;
    n_cmp++;
    if (rd0_data !== 32'h44) begin
      n_err++;
      $display("FAIL wr_with_clr_committed rd0=%h expected 44", rd0_data);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick;
      seen = clr_done;
    end
    tick;
    n_cmp++;
    if (!seen || rd0_data !== 32'h0) begin
      n_err++;
      $display("FAIL wr_with_clr_swept done_seen=%b rd0=%h expected 1/0", seen, rd0_data);
    end
  endtask

  task automatic test_clr_held;
    bit seen;
    clr_req = 1'b1;
    tick;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick;
      seen = clr_done;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL held_first_done got=0 expected 1 within 20 cycles");
    end
    tick;
    n_cmp++;
    if (busy !== 1'b0 || clr_done !== 1'b0) begin
      n_err++;
      $display("FAIL held_idle_gap busy=%b clr_done=%b expected 0/0", busy, clr_done);
    end
    tick;
    clr_req = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL held_restart busy=%b expected 1", busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick;
      seen = clr_done;
    end
    tick; tick;
    n_cmp++;
    if (!seen || busy !== 1'b0) begin
      n_err++;
      $display("FAIL held_second_done done_seen=%b busy=%b expected 1/0", seen, busy);
    end
  endtask

  task automatic test_reset_mid_sweep;
    bit bad;
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'hCAFE0006;
    tick;
    wr_en = 1'b0; rd0_addr = 3'd6; clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    tick; tick; tick;
    n_cmp++;
    if (rd0_data !== 32'hCAFE0006 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_sweep_pre rd0=%h busy=%b expected cafe0006/1", rd0_data, busy);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || clr_done !== 1'b0 || rd0_data !== 32'h0 || rd1_data !== 32'h0) begin
      n_err++;
      $display("FAIL mid_sweep_reset busy=%b done=%b rd0=%h rd1=%h expected all 0", busy, clr_done, rd0_data, rd1_data);
    end
    tick;
    reset_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (clr_done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL mid_sweep_no_done saw busy/clr_done after reset, expected none");
    end
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h0BADF00D;
    tick;
    wr_en = 1'b0; rd0_addr = 3'd1; rd1_addr = 3'd6;
    tick;
    n_cmp++;
    if (rd0_data !== 32'h0BADF00D || rd1_data !== 32'h0) begin
      n_err++;
      $display("FAIL mid_sweep_after rd0=%h expected 0badf00d rd1=%h expected 0", rd0_data, rd1_data);
    end
  endtask

  task automatic test_out_of_range;
    s_wr_en = 1'b1; s_wr_addr = 3'd6; s_wr_data = 32'h66666666;
    #1;
    n_cmp++;
    if (s_wr_ack !== 1'b0) begin
      n_err++;
      $display("FAIL oor_wr_ack got=%b expected 0", s_wr_ack);
    end
    tick;
    s_wr_addr = 3'd4; s_wr_data = 32'h00000055;
    #1;
    n_cmp++;
    if (s_wr_ack !== 1'b1) begin
      n_err++;
      $display("FAIL last_entry_wr_ack got=%b expected 1", s_wr_ack);
    end
    tick;
    s_wr_en = 1'b0; s_rd0_addr = 3'd4; s_rd1_addr = 3'd6;
    tick;
    n_cmp++;
    if (s_rd0_data !== 32'h55 || s_rd1_data !== 32'h0) begin
      n_err++;
      $display("FAIL oor_read rd0=%h expected 55 rd1=%h expected 0", s_rd0_data, s_rd1_data);
    end
  endtask

`ifdef REGFILE_BYTE_STROBE_EN
  task automatic test_byte_strobe;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'hAABBCCDD; wr_be = 4'hF;
    tick;
    wr_data = 32'h11223344; wr_be = 4'b0101; rd0_addr = 3'd1;
    tick;
    n_cmp++;
    if (rd0_data !== 32'hAA22CC44) begin
      n_err++;
      $display("FAIL strobe_bypass rd0=%h expected aa22cc44", rd0_data);
    end
    wr_data = 32'h99999999; wr_be = 4'b0000;
    #1;
    n_cmp++;
    if (wr_ack !== 1'b1) begin
      n_err++;
      $display("FAIL strobe_zero_ack got=%b expected 1", wr_ack);
    end
    tick;
    wr_en = 1'b0; wr_be = 4'hF;
    tick;
    n_cmp++;
    if (rd0_data !== 32'hAA22CC44) begin
      n_err++;
      $display("FAIL strobe_hold rd0=%h expected aa22cc44", rd0_data);
    end
  endtask
`endif

  initial begin
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
    rd0_addr = '0; rd1_addr = '0;
    s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    s_rd0_addr = '0; s_rd1_addr = '0;
`ifdef REGFILE_BYTE_STROBE_EN
    wr_be = 4'hF; s_wr_be = 4'hF;
`endif
    test_reset;
    test_write_read;
    test_bypass;
    test_sweep;
    test_wr_with_clr;
    test_clr_held;
    test_reset_mid_sweep;
    test_out_of_range;
`ifdef REGFILE_BYTE_STROBE_EN
    test_byte_strobe;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
